// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM encoding, round count, byte layout and
// the GF(2^8) helpers used by MixColumns.
package aes_pkg;

   localparam int BLOCK_W    = 128;
   localparam int NUM_ROUNDS = 10;
   localparam int BYTE_W     = 8;
   localparam int NUM_BYTES  = 16;
   localparam int NUM_COLS   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // One column, row 0 in the top byte.
   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/aes_cipher_core_sbox.sv
// Combinational AES S-box; one byte in, one substituted byte out.
module aes_sbox (
   input  logic [7:0] value,
   output logic [7:0] result
);

   // Entry 0 sits in the top byte, so ~value*8 addresses the matching slice.
   localparam logic [2047:0] TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign result = TABLE[{~value, 3'b000} +: 8];

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryptor, one round per clock, valid/ready on both sides.
// Build option AES_KEY_LATCH_EN: capture key1..key10 on acceptance into a local bank.
module aes_cipher_core
   import aes_pkg::*;
#(
   parameter int DATA_W = BLOCK_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] plaintext,
   input  logic [DATA_W-1:0] key0,
   input  logic [DATA_W-1:0] key1,
   input  logic [DATA_W-1:0] key2,
   input  logic [DATA_W-1:0] key3,
   input  logic [DATA_W-1:0] key4,
   input  logic [DATA_W-1:0] key5,
   input  logic [DATA_W-1:0] key6,
   input  logic [DATA_W-1:0] key7,
   input  logic [DATA_W-1:0] key8,
   input  logic [DATA_W-1:0] key9,
   input  logic [DATA_W-1:0] key10,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] ciphertext
);

   state_t            state, state_next;
   logic [3:0]        rnd, rnd_next;
   logic [DATA_W-1:0] st, st_next;
   logic [DATA_W-1:0] sb_out, sr_out, mc_out, round_key;
   logic [DATA_W-1:0] key_in  [1:NUM_ROUNDS];
   logic [DATA_W-1:0] key_src [1:NUM_ROUNDS];

   assign key_in = '{key1, key2, key3, key4, key5, key6, key7, key8, key9, key10};

`ifdef AES_KEY_LATCH_EN
   logic [DATA_W-1:0] key_bank [1:NUM_ROUNDS];

   // Key 0 is consumed on the acceptance edge itself, so only 1..10 are banked.
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid)
         key_bank <= key_in;
   end
   assign key_src = key_bank;
`else
   assign key_src = key_in;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
         // Byte gi is s[gi%4, gi/4]; ShiftRows pulls row r from column (c+r)%4.
         localparam int SRC = (gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4);
         aes_sbox u_sbox (
            .value  (st[DATA_W-1-BYTE_W*gi -: BYTE_W]),
            .result (sb_out[DATA_W-1-BYTE_W*gi -: BYTE_W])
         );
         assign sr_out[DATA_W-1-BYTE_W*gi -: BYTE_W] = sb_out[DATA_W-1-BYTE_W*SRC -: BYTE_W];
      end
      for (gi = 0; gi < NUM_COLS; gi++) begin : g_cols
         assign mc_out[DATA_W-1-32*gi -: 32] = mix_column(sr_out[DATA_W-1-32*gi -: 32]);
      end
   endgenerate

   always_comb begin
      round_key = key_src[1];
      for (int i = 2; i <= NUM_ROUNDS; i++) begin
         if (rnd == 4'(i))
            round_key = key_src[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         rnd   <= 4'd0;
         st    <= '0;
      end else begin
         state <= state_next;
         rnd   <= rnd_next;
         st    <= st_next;
      end
   end

   always_comb begin
      state_next = state;
      rnd_next   = rnd;
      st_next    = st;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               st_next    = plaintext ^ key0;
               rnd_next   = 4'd1;
               state_next = ROUND;
            end
         end
         ROUND: begin
            if (rnd == 4'(NUM_ROUNDS)) begin
               st_next    = sr_out ^ round_key;
               rnd_next   = 4'd0;
               state_next = DONE;
            end else begin
               st_next  = mc_out ^ round_key;
               rnd_next = rnd + 4'd1;
            end
         end
         DONE: begin
            if (out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign ciphertext = st;

endmodule
